// File: rtl/change_dispenser_if.sv
// Bundles the change_dispenser request inputs and its status/eject outputs.
// master: the requester (drives change_valid/change_amt, observes the rest).
// slave : the dispenser (the reverse).
// Optional macro CHANGE_DISPENSER_NICKEL_EN adds nickel_eject.
interface change_dispenser_if;
   logic        change_valid;
   logic [11:0] change_amt;
   logic        busy;
   logic        dollar_eject;
   logic        quarter_eject;
`ifdef CHANGE_DISPENSER_NICKEL_EN
   logic        nickel_eject;
`endif
   logic [11:0] remaining;
   logic [4:0]  leftover;
   logic        done;
   logic        drop;

`ifdef CHANGE_DISPENSER_NICKEL_EN
   modport master (output change_valid, change_amt,
                   input  busy, dollar_eject, quarter_eject, nickel_eject,
                          remaining, leftover, done, drop);
   modport slave  (input  change_valid, change_amt,
                   output busy, dollar_eject, quarter_eject, nickel_eject,
                          remaining, leftover, done, drop);
`else
   modport master (output change_valid, change_amt,
                   input  busy, dollar_eject, quarter_eject,
                          remaining, leftover, done, drop);
   modport slave  (input  change_valid, change_amt,
                   output busy, dollar_eject, quarter_eject,
                          remaining, leftover, done, drop);
`endif
endinterface

// File: rtl/change_dispenser.sv
// Coin change dispenser: takes a cent amount and ejects dollar and quarter
// coins (plus nickels when CHANGE_DISPENSER_NICKEL_EN is defined) as timed
// pulses, largest coin first, then reports the undispensable residue.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - change_dispenser_if.slave: change_valid/change_amt request in;
//            busy, *_eject, remaining, leftover, done, drop out (all registered)
// Parameters: PULSE_CYCLES (eject high time), GAP_CYCLES (low time between coins).
module change_dispenser #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 2
) (
   input  logic                clk,
   input  logic                reset,
   change_dispenser_if.slave   bus
);
   localparam int unsigned AMT_W  = 12;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned LEFT_W = 5;

   localparam logic [AMT_W-1:0] DOLLAR_C  = AMT_W'(100);
   localparam logic [AMT_W-1:0] QUARTER_C = AMT_W'(25);
`ifdef CHANGE_DISPENSER_NICKEL_EN
   localparam logic [AMT_W-1:0] NICKEL_C  = AMT_W'(5);
`endif
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      PULSE  = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Dispense sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= '0;
         bus.busy           <= 1'b0;
         bus.dollar_eject   <= 1'b0;
         bus.quarter_eject  <= 1'b0;
`ifdef CHANGE_DISPENSER_NICKEL_EN
         bus.nickel_eject   <= 1'b0;
`endif
         bus.remaining      <= '0;
         bus.leftover       <= '0;
         bus.done           <= 1'b0;
         bus.drop           <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         // Requests arriving outside IDLE (including the DONE cycle) are refused.
         bus.drop <= bus.change_valid && (state != IDLE);

         case (state)
            IDLE: begin
               if (bus.change_valid) begin
                  bus.remaining <= bus.change_amt;
                  bus.leftover  <= '0;
                  bus.busy      <= 1'b1;
                  state         <= SELECT;
               end
            end

            // Largest coin that fits; subtraction cannot underflow by construction.
            SELECT: begin
               if (bus.remaining >= DOLLAR_C) begin
                  bus.remaining    <= bus.remaining - DOLLAR_C;
                  bus.dollar_eject <= 1'b1;
                  cnt              <= PULSE_LOAD;
                  state            <= PULSE;
               end else if (bus.remaining >= QUARTER_C) begin
                  bus.remaining     <= bus.remaining - QUARTER_C;
                  bus.quarter_eject <= 1'b1;
                  cnt               <= PULSE_LOAD;
                  state             <= PULSE;
`ifdef CHANGE_DISPENSER_NICKEL_EN
               end else if (bus.remaining >= NICKEL_C) begin
                  bus.remaining    <= bus.remaining - NICKEL_C;
                  bus.nickel_eject <= 1'b1;
                  cnt              <= PULSE_LOAD;
                  state            <= PULSE;
`endif
               end else begin
                  bus.done      <= 1'b1;
                  bus.busy      <= 1'b0;
                  bus.leftover  <= bus.remaining[LEFT_W-1:0];
                  bus.remaining <= '0;
                  state         <= DONE;
               end
            end

            PULSE: begin
               if (cnt == '0) begin
                  bus.dollar_eject  <= 1'b0;
                  bus.quarter_eject <= 1'b0;
`ifdef CHANGE_DISPENSER_NICKEL_EN
                  bus.nickel_eject  <= 1'b0;
`endif
                  cnt   <= GAP_LOAD;
                  state <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            GAP: begin
               if (cnt == '0) begin
                  state <= SELECT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed and random requests
// compared cycle by cycle against a coin-list timeline model.
module tb_change_dispenser;
   localparam int P   = 4;
   localparam int G   = 2;
   localparam int PER = 1 + P + G;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   change_dispenser_if bus ();

   change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int busy, dol, qtr, nic, done, drop, remaining, leftover;
   } exp_t;

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int nic_obs();
`ifdef CHANGE_DISPENSER_NICKEL_EN
      return int'(bus.nickel_eject);
`else
      return 0;
`endif
   endfunction

   // Timeline model: coins greedily listed, each occupying PER samples after
   // the SELECT sample; sample 1 is the first sample after the accept edge.
   function automatic void model(input int amt, input int s, output exp_t e, output int last);
      int coins[$];
      int rem, idx, ph, paid;
      rem = amt;
      while (rem >= 100) begin coins.push_back(100); rem -= 100; end
      while (rem >= 25)  begin coins.push_back(25);  rem -= 25;  end
`ifdef CHANGE_DISPENSER_NICKEL_EN
      while (rem >= 5)   begin coins.push_back(5);   rem -= 5;   end
`endif
      last = 1 + coins.size() * PER;
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
      if (s <= last) begin
         e.busy = 1;
         idx = (s - 1) / PER;
         ph  = (s - 1) % PER;
         paid = 0;
         for (int i = 0; i < idx && i < coins.size(); i++) paid += coins[i];
         if (ph >= 1 && idx < coins.size()) begin
            paid += coins[idx];
            if (ph <= P) begin
               e.dol = (coins[idx] == 100) ? 1 : 0;
               e.qtr = (coins[idx] == 25)  ? 1 : 0;
               e.nic = (coins[idx] == 5)   ? 1 : 0;
            end
         end
         e.remaining = amt - paid;
      end else begin
         e.done     = (s == last + 1) ? 1 : 0;
         e.leftover = rem;
      end
   endfunction

   task automatic check_sample(input string tag, input exp_t e);
      chk({tag, ".busy"},      int'(bus.busy),          e.busy);
      chk({tag, ".dollar"},    int'(bus.dollar_eject),  e.dol);
      chk({tag, ".quarter"},   int'(bus.quarter_eject), e.qtr);
      chk({tag, ".nickel"},    nic_obs(),               e.nic);
      chk({tag, ".remaining"}, int'(bus.remaining),     e.remaining);
      chk({tag, ".leftover"},  int'(bus.leftover),      e.leftover);
      chk({tag, ".done"},      int'(bus.done),          e.done);
      chk({tag, ".drop"},      int'(bus.drop),          e.drop);
      chk({tag, ".one_hot"},
          int'(bus.dollar_eject) + int'(bus.quarter_eject) + nic_obs() <= 1 ? 1 : 0, 1);
   endtask

   // Issue a request and follow it to IDLE; inj>0 fires a stray 50-cent
   // request right after sample inj, which must only cause one drop pulse.
   task automatic run_req(input string tag, input int amt, input int inj);
      exp_t e;
      int   last, s;
      bus.change_valid = 1'b1;
      bus.change_amt   = 12'(amt);
      @(posedge clk); #1;
      bus.change_valid = 1'b0;
      model(amt, 1, e, last);
      s = 1;
      while (s <= last + 2) begin
         model(amt, s, e, last);
         e.drop = (inj > 0 && s == inj + 1) ? 1 : 0;
         check_sample($sformatf("%s@%0d", tag, s), e);
         if (s == inj) begin
            bus.change_valid = 1'b1;
            bus.change_amt   = 12'd50;
         end
         @(posedge clk); #1;
         bus.change_valid = 1'b0;
         s++;
      end
   endtask

   initial begin
      exp_t z;
      int   amt;
      z = '{0, 0, 0, 0, 0, 0, 0, 0};
      reset = 1'b1;
      bus.change_valid = 1'b0;
      bus.change_amt   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_sample("reset", z);
      reset = 1'b0;
      @(posedge clk); #1;

      run_req("amt175", 175, 0);
      run_req("amt0", 0, 0);
`ifndef CHANGE_DISPENSER_NICKEL_EN
      run_req("amt24", 24, 0);
`endif
      run_req("amt4095", 4095, 0);
      run_req("drop_pulse", 175, 9);   // during the 2nd coin pulse
      run_req("drop_done", 30, 9);     // in the DONE cycle

      // Reset mid-pulse, with a coincident request that must be discarded.
      bus.change_valid = 1'b1;
      bus.change_amt   = 12'd200;
      @(posedge clk); #1;
      bus.change_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset.dollar", int'(bus.dollar_eject), 1);
      reset = 1'b1;
      bus.change_valid = 1'b1;
      bus.change_amt   = 12'd50;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.change_valid = 1'b0;
      check_sample("abort", z);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_sample($sformatf("post_abort%0d", i), z);
      end
      run_req("amt25", 25, 0);

      for (int k = 0; k < 6; k++) begin
         amt = int'($urandom_range(0, 700));
         run_req($sformatf("rand%0d_%0d", k, amt), amt, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
